// File: rtl/jk_bank_sequencer.sv
// jk_bank_sequencer: round-robin shared N-bit master-slave JK bank sequencer.
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   req[1:0]          - level requests, held until the matching ack bit
//   op0/mask0         - requester 0 opcode and bit select
//   op1/mask1         - requester 1 opcode and bit select
//   ack[1:0]          - one-cycle grant pulse during the first MASTER cycle
//   busy              - high in MASTER and SLAVE
//   j_vec/k_vec       - J/K inputs to the bank, zero outside MASTER
//   q                 - slave (visible) bank state
//   done/err          - one-cycle completion pulse; err flags an illegal opcode
module jk_bank_sequencer #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [1:0]   req,
    input  logic [2:0]   op0,
    input  logic [N-1:0] mask0,
    input  logic [2:0]   op1,
    input  logic [N-1:0] mask1,
    output logic [1:0]   ack,
    output logic         busy,
    output logic [N-1:0] j_vec,
    output logic [N-1:0] k_vec,
    output logic [N-1:0] q,
    output logic         done,
    output logic         err
);
    typedef enum logic [1:0] {IDLE, MASTER, SLAVE} state_t;
    state_t state, state_nx;
    logic [2:0] op_l;
    logic [N-1:0] mask_l, m, up, dn;
    logic last_grant, win;
    // Requester 1 wins when it is alone, or on a tie when requester 0 was served last.
    assign win = req[1] & (~req[0] | ~last_grant);
    assign busy = state != IDLE;
    // up[i]/dn[i]: all lower bits are ones/zeros, i.e. bit i flips when counting.
    always_comb begin
        up[0] = 1'b1;
        dn[0] = 1'b1;
        for (int i = 1; i < N; i++) begin
            up[i] = up[i-1] & q[i-1];
            dn[i] = dn[i-1] & ~q[i-1];
        end
    end
    always_comb begin
        j_vec = '0;
        k_vec = '0;
        if (state == MASTER)
            case (op_l)
                3'b001: j_vec = mask_l;
                3'b010: k_vec = mask_l;
                3'b011: {j_vec, k_vec} = {mask_l, mask_l};
                3'b100: {j_vec, k_vec} = {up, up};
                3'b101: {j_vec, k_vec} = {dn, dn};
                default: ;
            endcase
    end
    always_comb begin
        state_nx = IDLE;
        case (state)
            IDLE:    state_nx = |req ? MASTER : IDLE;
            MASTER:  state_nx = SLAVE;
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            q          <= '0;
            m          <= '0;
            op_l       <= '0;
            mask_l     <= '0;
            last_grant <= 1'b1;
            ack        <= '0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            state <= state_nx;
            ack   <= '0;
            done  <= 1'b0;
            err   <= 1'b0;
            if (state == IDLE && |req) begin
                op_l       <= win ? op1 : op0;
                mask_l     <= win ? mask1 : mask0;
                last_grant <= win;
                ack        <= win ? 2'b10 : 2'b01;
            end
            if (state == MASTER)
                m <= (j_vec & ~q) | (~k_vec & q);
            if (state == SLAVE) begin
                q    <= m;
                done <= 1'b1;
                err  <= &op_l[2:1];
            end
        end
    end
endmodule

// File: tb/tb_jk_bank_sequencer.sv
// tb_jk_bank_sequencer: randomized and directed checks of jk_bank_sequencer against a transaction model.
module tb_jk_bank_sequencer;
    localparam int N = 4;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [1:0]   req = '0;
    logic [2:0]   op0 = '0;
    logic [N-1:0] mask0 = '0;
    logic [2:0]   op1 = '0;
    logic [N-1:0] mask1 = '0;
    logic [1:0]   ack;
    logic         busy;
    logic [N-1:0] j_vec;
    logic [N-1:0] k_vec;
    logic [N-1:0] q;
    logic         done;
    logic         err;
    int nvec = 0;
    int nerr = 0;
    logic [N-1:0] mq = '0;
    bit mlast = 1'b1;

    jk_bank_sequencer #(.N(N)) dut (
        .clk(clk), .rst(rst), .req(req), .op0(op0), .mask0(mask0), .op1(op1), .mask1(mask1),
        .ack(ack), .busy(busy), .j_vec(j_vec), .k_vec(k_vec), .q(q), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    function automatic logic [N-1:0] next_q(input logic [2:0] o, input logic [N-1:0] mk, input logic [N-1:0] cur);
        case (o)
            3'd1: return cur | mk;
            3'd2: return cur & ~mk;
            3'd3: return cur ^ mk;
            3'd4: return cur + N'(1);
            3'd5: return cur - N'(1);
            default: return cur;
        endcase
    endfunction

    function automatic logic [2*N-1:0] exp_jk(input logic [2:0] o, input logic [N-1:0] mk, input logic [N-1:0] cur);
        case (o)
            3'd1: return {mk, N'(0)};
            3'd2: return {N'(0), mk};
            3'd3: return {mk, mk};
            3'd4: return {cur ^ (cur + N'(1)), cur ^ (cur + N'(1))};
            3'd5: return {cur ^ (cur - N'(1)), cur ^ (cur - N'(1))};
            default: return '0;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_op(input logic [1:0] r, input logic [2:0] o0, input logic [N-1:0] k0,
                         input logic [2:0] o1, input logic [N-1:0] k1, input bit scramble);
        bit w;
        logic [2:0] o;
        logic [N-1:0] mk, nq;
        logic [2*N-1:0] ejk;
        logic [1:0] ea;
        logic [2*N+N+4:0] act, exp_v;
        req = r; op0 = o0; mask0 = k0; op1 = o1; mask1 = k1;
        w = (r == 2'b01) ? 1'b0 : (r == 2'b10) ? 1'b1 : ~mlast;
        o = w ? o1 : o0;
        mk = w ? k1 : k0;
        ejk = exp_jk(o, mk, mq);
        nq = next_q(o, mk, mq);
        ea = w ? 2'b10 : 2'b01;
        tick();
        act = {ack, busy, j_vec, k_vec, q, done, err};
        exp_v = {ea, 1'b1, ejk, mq, 1'b0, 1'b0};
        nvec++;
        if (act !== exp_v) begin
            nerr++;
            $display("FAIL master op=%0d req=%b: got {ack,busy,j,k,q,done,err}=%h want %h", o, r, act, exp_v);
        end
        mlast = w;
        req = '0;
        if (scramble) begin
            op0 = 3'($urandom()); mask0 = N'($urandom());
            op1 = 3'($urandom()); mask1 = N'($urandom());
        end
        tick();
        act = {ack, busy, j_vec, k_vec, q, done, err};
        exp_v = {2'b00, 1'b1, {(2*N){1'b0}}, mq, 1'b0, 1'b0};
        nvec++;
        if (act !== exp_v) begin
            nerr++;
            $display("FAIL slave op=%0d: got {ack,busy,j,k,q,done,err}=%h want %h", o, act, exp_v);
        end
        tick();
        mq = nq;
        act = {ack, busy, j_vec, k_vec, q, done, err};
        exp_v = {2'b00, 1'b0, {(2*N){1'b0}}, mq, 1'b1, &o[2:1]};
        nvec++;
        if (act !== exp_v) begin
            nerr++;
            $display("FAIL done op=%0d: got {ack,busy,j,k,q,done,err}=%h want %h", o, act, exp_v);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        tick();
        tick();
        rst = 1'b0;
        mq = '0;
        mlast = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        nvec++;
        if ({ack, busy, j_vec, k_vec, q, done, err} !== '0) begin
            nerr++;
            $display("FAIL reset: got {ack,busy,j,k,q,done,err}=%h want 0", {ack, busy, j_vec, k_vec, q, done, err});
        end
    endtask

    task automatic test_set_toggle();
        do_op(2'b01, 3'b001, 4'b0101, 3'b000, 4'b0000, 1'b0);
        do_op(2'b10, 3'b000, 4'b0000, 3'b011, 4'b0011, 1'b1);
        nvec++;
        if (q !== 4'b0110) begin
            nerr++;
            $display("FAIL toggle_result: got q=%b want 0110", q);
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        do_op(2'b10, 3'b000, 4'b0000, 3'b001, 4'b1110, 1'b0);
        do_op(2'b11, 3'b100, 4'b0000, 3'b100, 4'b0000, 1'b0);
        do_op(2'b11, 3'b100, 4'b0000, 3'b100, 4'b0000, 1'b0);
        do_op(2'b11, 3'b100, 4'b0000, 3'b100, 4'b0000, 1'b0);
        nvec++;
        if (q !== 4'b0001) begin
            nerr++;
            $display("FAIL wrap_up: got q=%b want 0001", q);
        end
    endtask

    task automatic test_count_down();
        do_op(2'b01, 3'b010, 4'b0001, 3'b000, 4'b0000, 1'b0);
        do_op(2'b01, 3'b101, 4'b1010, 3'b000, 4'b0000, 1'b0);
        do_op(2'b01, 3'b010, 4'b1000, 3'b000, 4'b0000, 1'b0);
        nvec++;
        if (q !== 4'b0111) begin
            nerr++;
            $display("FAIL down_reset: got q=%b want 0111", q);
        end
    endtask

    task automatic test_illegal();
        do_op(2'b10, 3'b000, 4'b0000, 3'b111, 4'b1111, 1'b0);
        do_op(2'b01, 3'b110, 4'b1111, 3'b000, 4'b0000, 1'b0);
    endtask

    task automatic test_reset_mid();
        req = 2'b01; op0 = 3'b001; mask0 = 4'b1111;
        tick();
        req = '0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        mq = '0;
        mlast = 1'b1;
        nvec++;
        if ({q, busy, done, ack} !== '0) begin
            nerr++;
            $display("FAIL reset_mid: got {q,busy,done,ack}=%h want 0", {q, busy, done, ack});
        end
        do_op(2'b11, 3'b011, 4'b1001, 3'b001, 4'b0110, 1'b0);
    endtask

    task automatic test_drop();
        req = 2'b10; op1 = 3'b001; mask1 = 4'b0010;
        tick();
        req = '0;
        tick();
        req = 2'b01; op0 = 3'b001; mask0 = 4'b1111;
        tick();
        req = '0;
        mq = mq | 4'b0010;
        mlast = 1'b1;
        tick();
        tick();
        nvec++;
        if ({ack, busy, done, q} !== {2'b00, 1'b0, 1'b0, mq}) begin
            nerr++;
            $display("FAIL drop: got {ack,busy,done,q}=%h want %h", {ack, busy, done, q}, {2'b00, 1'b0, 1'b0, mq});
        end
    endtask

    task automatic test_back_to_back_random();
        for (int n = 0; n < 300; n++) begin
            do_op(2'($urandom_range(1, 3)), 3'($urandom()), N'($urandom()), 3'($urandom()), N'($urandom()), 1'b1);
            repeat ($urandom_range(0, 2)) begin
                tick();
                nvec++;
                if ({ack, busy, q} !== {2'b00, 1'b0, mq}) begin
                    nerr++;
                    $display("FAIL idle: got {ack,busy,q}=%h want %h", {ack, busy, q}, {2'b00, 1'b0, mq});
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_set_toggle();
        test_round_robin();
        test_count_down();
        test_illegal();
        test_reset_mid();
        test_drop();
        test_back_to_back_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/jk_bank_sequencer.md
Name: jk_bank_sequencer

Overview:
- Sequences an N-bit bank of master-slave JK stages and shares it between two requesters under round-robin arbitration.
- Each granted command becomes J/K vectors. The command runs as a two-phase master-capture / slave-transfer sequence, so the bank output q changes only once per operation.
- Sits between command sources (test FSMs, counters) and the JK register datapath. It is the single owner of the bank's J/K inputs.

Parameters:
- N, 4, bank width in bits (N >= 2).

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst  input  1  synchronous active-high reset.
- req  input  2  req[i] = requester i has a command pending; level, held until ack[i].
- op0  input  3  requester 0 opcode.
- mask0  input  N  requester 0 bit select.
- op1  input  3  requester 1 opcode.
- mask1  input  N  requester 1 bit select.
- ack  output  2  one-cycle grant pulse, one-hot or zero.
- busy  output  1  high while state != IDLE.
- j_vec  output  N  J inputs presented to the bank; zero outside MASTER.
- k_vec  output  N  K inputs presented to the bank; zero outside MASTER.
- q  output  N  slave (visible) bank state.
- done  output  1  one-cycle pulse; q already holds the new value.
- err  output  1  one-cycle pulse coincident with done for an illegal opcode.

Behaviour:
- Reset (synchronous, active-high, wins over everything including mid-operation):
  - state=IDLE; q=0; master m=0.
  - ack=0, done=0, err=0, j_vec=0, k_vec=0, busy=0.
  - last_grant=1, so requester 0 wins the first tie.
  - Any in-flight command is discarded and q does not update.
- Opcodes (J/K per bit i):
  - 000 HOLD: J=0, K=0.
  - 001 SET: J=mask, K=0.
  - 010 RESET: J=0, K=mask.
  - 011 TOGGLE: J=K=mask.
  - 100 COUNT_UP: mask ignored. J[i]=K[i]=1 iff q[i-1:0] all ones; bit 0 always toggles. Wraps all-ones -> 0.
  - 101 COUNT_DOWN: mask ignored. J[i]=K[i]=1 iff q[i-1:0] all zeros; bit 0 always toggles. Wraps 0 -> all-ones.
  - 110/111: executed as HOLD; err=1 alongside done.
- JK function per bit, computed from the slave q:
  - J=0,K=0 -> q
  - J=1,K=0 -> 1
  - J=0,K=1 -> 0
  - J=1,K=1 -> ~q
- FSM: IDLE -> MASTER -> SLAVE -> IDLE.
  - IDLE, req==0: stay in IDLE.
  - IDLE, req!=0: pick a winner.
    - If only one request is active, that requester wins.
    - If both are active, the winner is the one not equal to last_grant.
    - On the posedge: latch the winner's op/mask, last_grant<=winner, go to MASTER.
    - ack[winner] is registered: it is high during the first MASTER cycle only.
  - MASTER (1 cycle): j_vec/k_vec driven combinationally from the latched op/mask and q. On the posedge, m<=JK(j_vec,k_vec,q) and the FSM goes to SLAVE. q is unchanged.
  - SLAVE (1 cycle): on the posedge, q<=m and the FSM goes to IDLE. done (and err if applicable) is registered high for the following cycle.
- Latency:
  - req sampled at cycle t -> ack at t+1 -> q updated and done high at t+3.
  - Back-to-back throughput is 3 cycles per operation. IDLE may accept a new request in the same cycle done is high.
- Requests:
  - Requests are sampled only in IDLE. A request deasserted before its ack is dropped silently.
  - Opcode/mask changes after ack have no effect on the running command.
- busy is high in MASTER and SLAVE.
- q never changes except on the SLAVE->IDLE posedge or reset.
- No glitch on j_vec/k_vec outside MASTER: they are forced to zero.

Test Plan:
- Reset, then req=01, op0=001, mask0=0101 -> ack=01 one cycle later; q=0101 and done=1 three cycles after the req sample; err=0.
- From q=0101: req=10, op1=011, mask1=0011 -> j_vec=k_vec=0011 during MASTER only; q unchanged until done, then q=0110.
- Both req held with op0=100, op1=100 from q=1110 after reset -> acks alternate 01,10,01. q sequence 1111, 0000, 0001: wrap-around verified.
- op0=101 from q=0000 -> q=1111; then op0=010, mask0=1000 -> q=0111.
- op1=111 from q=0111 -> done=1 and err=1 in the same cycle; q stays 0111; j_vec=k_vec=0 throughout.
- rst asserted during SLAVE of a SET 1111 -> next cycle q=0000, busy=0, done=0. The next tie is granted to requester 0.
